// File: rtl/pic_nchan.sv
// N-channel programmable interrupt controller: edge/level requests, rotating
// priority, fully nested in-service tracking and a two-pulse INTA vector handshake.
module pic_nchan #(
  parameter int unsigned N_IRQ     = 8,
  parameter logic [7:0]  VBASE_RST = 8'h20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CS,
  input  logic             WR,
  input  logic             RD,
  input  logic [2:0]       ADDR,
  input  logic [31:0]      WDATA,
  output logic [31:0]      RDATA,
  input  logic [N_IRQ-1:0] IR,
  input  logic             INTA,
  output logic             INT,
  output logic [7:0]       VECTOR,
  output logic             VECTOR_VALID
);

  localparam int unsigned      IW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [IW-1:0]    LAST = IW'(N_IRQ - 1);
  localparam logic [N_IRQ-1:0] ONE  = {{(N_IRQ-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK1 = 1'b1;

  logic [2:0]       ctrl;
  logic [7:0]       vbase;
  logic [N_IRQ-1:0] imr;
  logic [N_IRQ-1:0] isr;
  logic [N_IRQ-1:0] latch;
  logic [N_IRQ-1:0] ir_q;
  logic [IW-1:0]    low_pri;
  logic [0:0]       state;
  logic [IW-1:0]    win_q;
  logic             spur_q;
  logic [31:0]      rdata_q;
  logic             int_q;
  logic [7:0]       vector_q;
  logic             vector_valid_q;

  logic             ltim, aeoi, rot;
  logic             wr_en, rd_en, ctrl_wr, eoi_wr, inta1, inta2;
  logic [N_IRQ-1:0] irr, pend;
  logic             unused_wdata;

  assign ltim    = ctrl[0];
  assign aeoi    = ctrl[1];
  assign rot     = ctrl[2];
  assign wr_en   = CS & WR;
  assign rd_en   = CS & RD;
  assign ctrl_wr = wr_en && (ADDR == 3'd0);
  assign eoi_wr  = wr_en && (ADDR == 3'd3);
  assign inta1   = INTA && (state == ST_IDLE);
  assign inta2   = INTA && (state == ST_ACK1);
  assign irr     = ltim ? ir_q : latch;
  assign pend    = irr & ~imr;
  assign unused_wdata = &{1'b0, WDATA};

  // Channel holding priority position k (0 = highest) for a given lowest-priority channel.
  function automatic logic [IW-1:0] chan_at(input logic [IW-1:0] lp, input int unsigned k);
    int unsigned s;
    s = 32'(lp) + 32'd1 + k;
    if (s >= N_IRQ) s = s - N_IRQ;
    return IW'(s);
  endfunction

  logic [IW-1:0] scan_c;
  logic [IW-1:0] pend_idx, isr_idx;
  logic          pend_any, isr_any, pend_wins;

  // Walk channels in priority order; a request wins only if seen before any in-service bit.
  always_comb begin
    scan_c    = '0;
    pend_idx  = LAST;
    isr_idx   = '0;
    pend_any  = 1'b0;
    isr_any   = 1'b0;
    pend_wins = 1'b0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      scan_c = chan_at(low_pri, k);
      if (isr[scan_c] && !isr_any) begin
        isr_any = 1'b1;
        isr_idx = scan_c;
      end
      if (pend[scan_c] && !pend_any) begin
        pend_any  = 1'b1;
        pend_idx  = scan_c;
        pend_wins = !isr_any;
      end
    end
  end

  logic [N_IRQ-1:0] eoi_clr;
  logic             eoi_rot;
  logic [IW-1:0]    eoi_lp;

  always_comb begin
    eoi_clr = '0;
    eoi_rot = 1'b0;
    eoi_lp  = low_pri;
    if (eoi_wr) begin
      if (WDATA[7]) begin
        if ({27'b0, WDATA[4:0]} < N_IRQ) begin
          eoi_clr = ONE << WDATA[4:0];
          eoi_rot = WDATA[6];
          eoi_lp  = IW'(WDATA[4:0]);
        end
      end else if (isr_any) begin
        eoi_clr = ONE << isr_idx;
        eoi_rot = WDATA[6];
        eoi_lp  = isr_idx;
      end
    end
  end

  logic [N_IRQ-1:0] ack_set, aeoi_clr, isr_nxt, latch_nxt;
  logic             aeoi_hit;
  logic [IW-1:0]    lp_nxt;

  // Specific/non-specific EOI and automatic EOI may land together; both clears apply.
  always_comb begin
    aeoi_hit  = inta2 && aeoi && !spur_q;
    aeoi_clr  = aeoi_hit ? (ONE << win_q) : '0;
    ack_set   = (inta1 && pend_any) ? (ONE << pend_idx) : '0;
    isr_nxt   = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
    latch_nxt = (latch & ~ack_set) | (IR & ~ir_q);
    if (eoi_rot)              lp_nxt = eoi_lp;
    else if (aeoi_hit && rot) lp_nxt = win_q;
    else                      lp_nxt = low_pri;
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (ADDR)
      3'd0:    rd_mux[2:0]       = ctrl;
      3'd1:    rd_mux[7:0]       = vbase;
      3'd2:    rd_mux[N_IRQ-1:0] = imr;
      3'd3:    rd_mux[N_IRQ-1:0] = irr;
      3'd4:    rd_mux[N_IRQ-1:0] = isr;
      3'd5:    rd_mux[IW:0]      = {low_pri, state};
      default: rd_mux            = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl           <= '0;
      vbase          <= VBASE_RST;
      imr            <= '0;
      isr            <= '0;
      latch          <= '0;
      ir_q           <= '0;
      low_pri        <= LAST;
      state          <= ST_IDLE;
      win_q          <= '0;
      spur_q         <= 1'b0;
      rdata_q        <= '0;
      int_q          <= 1'b0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      ir_q           <= IR;
      int_q          <= pend_wins;
      vector_valid_q <= 1'b0;
      if (rd_en) rdata_q <= rd_mux;
      if (wr_en && (ADDR == 3'd1)) vbase <= WDATA[7:0];
      if (ctrl_wr) begin
        ctrl    <= WDATA[2:0];
        isr     <= '0;
        latch   <= '0;
        imr     <= '0;
        low_pri <= LAST;
        state   <= ST_IDLE;
      end else begin
        if (wr_en && (ADDR == 3'd2)) imr <= WDATA[N_IRQ-1:0];
        isr     <= isr_nxt;
        latch   <= latch_nxt;
        low_pri <= lp_nxt;
        if (inta1) begin
          win_q  <= pend_any ? pend_idx : LAST;
          spur_q <= !pend_any;
          state  <= ST_ACK1;
        end else if (inta2) begin
          vector_q       <= vbase + 8'(win_q);
          vector_valid_q <= 1'b1;
          state          <= ST_IDLE;
        end
      end
    end
  end

  assign RDATA        = rdata_q;
  assign INT          = int_q;
  assign VECTOR       = vector_q;
  assign VECTOR_VALID = vector_valid_q;

endmodule

// File: tb/tb_pic_nchan.sv
// Directed bench for pic_nchan: a rank-arithmetic reference model checked every
// cycle, plus hand-computed expectations for the main scenarios.
module tb_pic_nchan;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RESET, CS, WR, RD, INTA;
  logic [2:0]   ADDR;
  logic [31:0]  WDATA;
  logic [N-1:0] IR;
  logic [31:0]  RDATA;
  logic         INT;
  logic [7:0]   VECTOR;
  logic         VECTOR_VALID;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  pic_nchan #(.N_IRQ(N), .VBASE_RST(8'h20)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .WR(WR), .RD(RD), .ADDR(ADDR),
    .WDATA(WDATA), .RDATA(RDATA), .IR(IR), .INTA(INTA), .INT(INT),
    .VECTOR(VECTOR), .VECTOR_VALID(VECTOR_VALID)
  );

  always #5 CLK = ~CLK;

  bit          m_ltim, m_aeoi, m_rot, m_ack, m_spur, m_int, m_vv;
  int          m_vbase, m_lp, m_w, m_vec;
  bit [N-1:0]  m_imr, m_isr, m_lat, m_irq;
  logic [31:0] m_rdata;

  function automatic int rank(int i, int lp);
    return (i - lp - 1 + 2 * N) % N;
  endfunction

  function automatic int best(bit [N-1:0] v, int lp);
    int b;
    b = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (b < 0 || rank(i, lp) < rank(b, lp))) b = i;
    return b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ltim = 0; m_aeoi = 0; m_rot = 0; m_ack = 0; m_spur = 0;
    m_int = 0; m_vv = 0; m_vbase = 'h20; m_lp = N - 1; m_w = 0; m_vec = 0;
    m_imr = '0; m_isr = '0; m_lat = '0; m_irq = '0; m_rdata = '0;
  endtask

  // Applies the current inputs to the model as if a rising edge occurred.
  task automatic model_step();
    bit [N-1:0] irr, pend, n_isr, n_lat, n_imr;
    int w, t, n_lp, lvl, n_vbase, n_vec, n_w;
    bit n_ack, n_spur, n_vv, n_int, n_ltim, n_aeoi, n_rot;
    logic [31:0] n_rdata;
    if (RESET) begin
      model_reset();
      return;
    end
    irr = m_ltim ? m_irq : m_lat;
    pend = irr & ~m_imr;
    w = best(pend, m_lp);
    t = best(m_isr, m_lp);
    n_int = (w >= 0) && (t < 0 || rank(w, m_lp) < rank(t, m_lp));
    n_isr = m_isr; n_lat = m_lat; n_imr = m_imr; n_lp = m_lp; n_vbase = m_vbase;
    n_vec = m_vec; n_w = m_w; n_ack = m_ack; n_spur = m_spur; n_vv = 0;
    n_ltim = m_ltim; n_aeoi = m_aeoi; n_rot = m_rot; n_rdata = m_rdata;
    if (CS && RD) begin
      case (ADDR)
        3'd0: n_rdata = {29'b0, m_rot, m_aeoi, m_ltim};
        3'd1: n_rdata = m_vbase;
        3'd2: n_rdata = {24'b0, m_imr};
        3'd3: n_rdata = {24'b0, irr};
        3'd4: n_rdata = {24'b0, m_isr};
        3'd5: n_rdata = m_lp * 2 + (m_ack ? 1 : 0);
        default: n_rdata = 0;
      endcase
    end
    if (CS && WR && ADDR == 3'd1) n_vbase = WDATA[7:0];
    if (CS && WR && ADDR == 3'd0) begin
      n_ltim = WDATA[0]; n_aeoi = WDATA[1]; n_rot = WDATA[2];
      n_isr = '0; n_lat = '0; n_imr = '0; n_lp = N - 1; n_ack = 0;
    end else begin
      if (CS && WR && ADDR == 3'd2) n_imr = WDATA[N-1:0];
      if (m_ack && INTA) begin
        n_vec = (m_vbase + m_w) % 256; n_vv = 1; n_ack = 0;
        if (m_aeoi && !m_spur) begin
          n_isr[m_w] = 0;
          if (m_rot) n_lp = m_w;
        end
      end
      if (CS && WR && ADDR == 3'd3) begin
        if (WDATA[7]) begin
          lvl = WDATA[4:0];
          if (lvl < N) begin
            n_isr[lvl] = 0;
            if (WDATA[6]) n_lp = lvl;
          end
        end else if (t >= 0) begin
          n_isr[t] = 0;
          if (WDATA[6]) n_lp = t;
        end
      end
      if (!m_ack && INTA) begin
        n_ack = 1;
        if (w >= 0) begin
          n_isr[w] = 1; n_lat[w] = 0; n_w = w; n_spur = 0;
        end else begin
          n_w = N - 1; n_spur = 1;
        end
      end
      for (int i = 0; i < N; i++)
        if (IR[i] && !m_irq[i]) n_lat[i] = 1;
    end
    m_irq = IR;
    m_isr = n_isr; m_lat = n_lat; m_imr = n_imr; m_lp = n_lp; m_vbase = n_vbase;
    m_vec = n_vec; m_w = n_w; m_ack = n_ack; m_spur = n_spur; m_vv = n_vv;
    m_int = n_int; m_ltim = n_ltim; m_aeoi = n_aeoi; m_rot = n_rot; m_rdata = n_rdata;
  endtask

  always @(posedge CLK) begin
    #1;
    if (chk_on) begin
      check("int", {31'b0, INT}, {31'b0, m_int});
      check("vector", {24'b0, VECTOR}, m_vec);
      check("vector_valid", {31'b0, VECTOR_VALID}, {31'b0, m_vv});
      check("rdata", RDATA, m_rdata);
    end
  end

  task automatic step();
    model_step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    CS = 1; WR = 1; ADDR = a; WDATA = d;
    step();
    CS = 0; WR = 0;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] exp, string name);
    CS = 1; RD = 1; ADDR = a;
    step();
    CS = 0; RD = 0;
    check(name, RDATA, exp);
  endtask

  task automatic ack();
    INTA = 1;
    step();
    INTA = 0;
  endtask

  initial begin
    RESET = 1; CS = 0; WR = 0; RD = 0; INTA = 0; ADDR = '0; WDATA = '0; IR = '0;
    model_reset();
    chk_on = 1;
    idle(3);
    check("rst_int", {31'b0, INT}, 0);
    check("rst_vector", {24'b0, VECTOR}, 0);
    RESET = 0;
    idle(2);
    rd(3'd1, 32'h20, "rst_vbase");
    rd(3'd5, 32'h0e, "rst_lowpri");

    // edge-mode acknowledge
    IR = 8'h08;
    idle(2);
    check("edge_int", {31'b0, INT}, 1);
    ack();
    rd(3'd4, 32'h08, "edge_isr");
    rd(3'd3, 32'h00, "edge_irr");
    check("edge_int_drop", {31'b0, INT}, 0);
    ack();
    check("edge_vec", {24'b0, VECTOR}, 32'h23);
    check("edge_vv", {31'b0, VECTOR_VALID}, 1);
    step();
    check("edge_vv_pulse", {31'b0, VECTOR_VALID}, 0);
    check("vec_hold", {24'b0, VECTOR}, 32'h23);
    wr(3'd3, 32'h00);
    rd(3'd4, 32'h00, "edge_eoi");
    IR = 0;
    idle(2);

    // nesting
    IR = 8'h20; step(); IR = 0; idle(2);
    ack(); ack();
    check("nest_vec5", {24'b0, VECTOR}, 32'h25);
    IR = 8'h40; idle(3);
    check("nest_low_blocked", {31'b0, INT}, 0);
    IR = 8'h44; idle(2);
    check("nest_high_int", {31'b0, INT}, 1);
    ack(); ack();
    check("nest_vec2", {24'b0, VECTOR}, 32'h22);
    rd(3'd4, 32'h24, "nest_isr");
    wr(3'd3, 32'h89);
    rd(3'd4, 32'h24, "eoi_lvl_oor");
    wr(3'd3, 32'hC5);
    rd(3'd4, 32'h04, "eoi_spec_rot");
    rd(3'd5, 32'h0a, "eoi_rot_lowpri");
    wr(3'd3, 32'h00);
    rd(3'd4, 32'h00, "eoi_nonspec");
    IR = 0; step();
    wr(3'd0, 32'h0);
    idle(2);

    // masking in level mode
    wr(3'd0, 32'h1);
    wr(3'd2, 32'h08);
    IR = 8'h08; idle(3);
    check("mask_int", {31'b0, INT}, 0);
    rd(3'd3, 32'h08, "mask_irr");
    wr(3'd2, 32'h00);
    step();
    check("unmask_int", {31'b0, INT}, 1);
    IR = 0; step();
    wr(3'd0, 32'h0);
    idle(2);

    // rotation with AEOI
    wr(3'd0, 32'h6);
    IR = 8'h12; step(); IR = 0; idle(2);
    ack(); ack();
    check("rot_vec1", {24'b0, VECTOR}, 32'h21);
    rd(3'd5, 32'h02, "rot_lowpri");
    IR = 8'h02; step(); IR = 0; idle(2);
    ack(); ack();
    check("rot_vec4", {24'b0, VECTOR}, 32'h24);
    rd(3'd4, 32'h00, "rot_aeoi_isr");
    wr(3'd0, 32'h0);
    idle(2);

    // spurious, including vector wrap
    ack(); ack();
    check("spur_vec", {24'b0, VECTOR}, 32'h27);
    rd(3'd4, 32'h00, "spur_isr");
    wr(3'd1, 32'hFC);
    ack(); ack();
    check("spur_wrap", {24'b0, VECTOR}, 32'h03);
    wr(3'd1, 32'h20);

    // reset mid-handshake
    IR = 8'h01; step(); IR = 0; idle(2);
    ack();
    rd(3'd5, 32'h0f, "ack1_state");
    RESET = 1;
    model_reset();
    step();
    RESET = 0;
    step();
    check("abort_vv", {31'b0, VECTOR_VALID}, 0);
    check("abort_vec", {24'b0, VECTOR}, 0);
    rd(3'd4, 32'h00, "abort_isr");
    rd(3'd5, 32'h0e, "abort_state");
    idle(2);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
